regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-side front end for the CPU register file. Merges the in-order pipeline writeback stream and the out-of-order long-latency unit (mul/div) result stream onto the register file's single write port (load/dest/in). Keeps a per-register pending scoreboard for long-latency destinations and raises a decode hazard stall on read-after-pending. Sits between the writeback stage, the long-latency unit, decode, and the register file.

## Interface
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive cycles a buffered result may wait before a bubble is requested

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe_wb_valid  in  1  pipeline writeback valid; never back-pressured
- pipe_wb_dest  in  5  pipeline writeback destination
- pipe_wb_data  in  32  pipeline writeback data
- lu_issue  in  1  long-latency op issued this cycle
- lu_issue_dest  in  5  destination of issued op
- lu_valid  in  1  long-latency result valid
- lu_dest  in  5  result destination
- lu_data  in  32  result data
- lu_ready  out  1  result buffer can accept (registered)
- rs1, rs2  in  5  decode source registers
- hazard_stall  out  1  decode must stall (combinational)
- wb_stall_req  out  1  request one pipeline writeback bubble (registered)
- rf_load  out  1  register file write enable (registered)
- rf_dest  out  5  register file write address (registered)
- rf_in  out  32  register file write data (registered)
- pending  out  32  scoreboard bitmap; bit 0 always 0

## Operation
- Result FIFO: push on lu_valid && lu_ready; lu_ready = (count < FIFO_DEPTH), computed from registered count.
- Arbitration per cycle: pipe_wb_valid && pipe_wb_dest != 0 wins → output pipe write. Otherwise, FIFO non-empty → pop head, output it. Otherwise rf_load = 0.
- Writes to x0 never assert rf_load; pipeline write to x0 counts as idle (FIFO may drain that cycle). FIFO entry with dest 0 is popped and discarded (rf_load = 0) but still pops.
- Internal flag src_lu registered alongside rf_* marks the output as a FIFO result.
- Scoreboard: lu_issue && lu_issue_dest != 0 sets pending[lu_issue_dest]. Clear on the edge where rf_load && src_lu && pending[rf_dest] (the edge the register file captures the value). Same-edge set and clear of the same register: set wins.
- Pipeline writes never modify pending.
- hazard_stall = (rs1 != 0 && pending[rs1]) || (rs2 != 0 && pending[rs2]).
- Starvation counter: increments each cycle FIFO non-empty and no pop; resets to 0 on pop or empty. When count reaches STARVE_LIMIT, wb_stall_req = 1 the next cycle and stays until a pop occurs; counter saturates.
- Reset: FIFO empty, pending = 0, counter = 0, rf_load = 0, rf_dest = 0, rf_in = 0, src_lu = 0, wb_stall_req = 0, lu_ready = 1 after reset deassert (0 while rst high).

## Timing
- Source → rf_* : 1 cycle latency (rf_* updated at the edge after the source cycle); register file stores one edge later.
- lu_valid accepted at edge N with empty FIFO and no pipeline write at N+1 → rf_load high in cycle N+2 (FIFO read registered via pop in N+1).
- Pending clear visible in cycle after the register-file write edge; hazard_stall drops in the same cycle the new value is readable.
- Push and pop in same cycle with full FIFO: push refused (lu_ready already 0); with count = FIFO_DEPTH-1: both allowed, count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation: all state cleared immediately; buffered results are lost.

## Test plan
- Reset: assert rst mid-stream with 2 FIFO entries → rf_load=0, pending=0, lu_ready=0 during reset, 1 the cycle after release.
- Priority: pipe_wb x5=0xAAAA_0001 and FIFO head x6=0x1234 same cycle → rf writes x5 first, x6 next cycle.
- Scoreboard: issue to x7, rs1=7 → hazard_stall=1; result x7=0xDEAD_BEEF → stall clears the cycle after the regfile write edge; issue to x0 → pending stays 0.
- Back-pressure: 3 back-to-back lu_valid with pipe_wb_valid every cycle → third held by lu_ready=0; no loss or reorder.
- Starvation: continuous pipe writes with FIFO non-empty → wb_stall_req=1 after 8 cycles; one idle pipeline cycle pops and deasserts it.
- Same-edge set/clear: result for x9 emitted while new issue to x9 → pending[9] remains 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-side front end for the CPU register file. Two producers share the
// register file's single write port:
//   - the in-order pipeline writeback stream, which is never back-pressured
//     and therefore always wins arbitration;
//   - the out-of-order long-latency unit (mul/div), whose results are buffered
//     in a small FIFO and drained whenever the pipeline does not write.
// A per-register pending scoreboard tracks outstanding long-latency
// destinations. Decode stalls on read-after-pending. If buffered results
// starve for too long, the block asks the pipeline for a writeback bubble.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   pipe_wb_*         pipeline writeback (valid, dest, data)
//   lu_issue*         long-latency op issued (marks dest pending)
//   lu_valid/dest/data, lu_ready
//                     long-latency result handshake into the FIFO
//   rs1, rs2          decode source registers
//   hazard_stall      combinational decode stall (source is pending)
//   wb_stall_req      registered request for one pipeline writeback bubble
//   rf_load/dest/in   registered register-file write port
//   pending           scoreboard bitmap (bit 0 always 0)

module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_dest,
  input  logic [31:0] pipe_wb_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_dest,
  input  logic        lu_valid,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard_stall,
  output logic        wb_stall_req,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in,
  output logic [31:0] pending
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STV_ZERO  = SW'(0);
  localparam logic [SW-1:0] STV_ONE   = SW'(1);
  localparam logic [SW-1:0] STV_LIMIT = SW'(STARVE_LIMIT);

  // Result FIFO storage and bookkeeping
  logic [4:0]    fifo_dest_r [FIFO_DEPTH];
  logic [31:0]   fifo_data_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic          lu_ready_r;

  logic          pipe_win_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  logic [4:0]    head_dest_s;
  logic [31:0]   head_data_s;

  // Write-port output registers; src_lu_r marks a FIFO-sourced write
  logic          rf_load_r;
  logic [4:0]    rf_dest_r;
  logic [31:0]   rf_in_r;
  logic          src_lu_r;

  // Scoreboard
  logic [31:0]   pending_r;
  logic [31:0]   pending_s;
  logic [31:0]   set_s;
  logic [31:0]   clr_s;

  // Starvation tracking
  logic [SW-1:0] starve_cnt_r;
  logic [SW-1:0] starve_cnt_s;
  logic          wb_stall_req_r;
  logic          wb_stall_req_s;

  // Arbitration: a pipeline write to x0 is treated as idle so the FIFO may drain
  always_comb begin
    pipe_win_s   = pipe_wb_valid && (pipe_wb_dest != 5'd0);
    fifo_empty_s = (count_r == CNT_ZERO);
    push_s       = lu_valid && lu_ready_r;
    pop_s        = !pipe_win_s && !fifo_empty_s;
    head_dest_s  = fifo_dest_r[rd_ptr_r];
    head_data_s  = fifo_data_r[rd_ptr_r];
  end

  // Next FIFO occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and registered ready (low while in reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= CNT_ZERO;
      lu_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_s;
      lu_ready_r <= (count_s < CNT_FULL);
    end
  end

  // FIFO entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dest_r[i] <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      fifo_dest_r[wr_ptr_r] <= lu_dest;
      fifo_data_r[wr_ptr_r] <= lu_data;
    end
  end

  // Register-file write port: pipeline first, then FIFO head; x0 entries are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_load_r <= 1'b0;
      rf_dest_r <= 5'd0;
      rf_in_r   <= 32'd0;
      src_lu_r  <= 1'b0;
    end else if (pipe_win_s) begin
      rf_load_r <= 1'b1;
      rf_dest_r <= pipe_wb_dest;
      rf_in_r   <= pipe_wb_data;
      src_lu_r  <= 1'b0;
    end else if (pop_s) begin
      rf_load_r <= (head_dest_s != 5'd0);
      rf_dest_r <= head_dest_s;
      rf_in_r   <= head_data_s;
      src_lu_r  <= 1'b1;
    end else begin
      rf_load_r <= 1'b0;
      src_lu_r  <= 1'b0;
    end
  end

  // Scoreboard update: clear on the edge the register file captures a FIFO result; a same-edge issue wins
  always_comb begin
    set_s = 32'd0;
    clr_s = 32'd0;
    if (lu_issue && (lu_issue_dest != 5'd0)) begin
      set_s[lu_issue_dest] = 1'b1;
    end else begin
      set_s = 32'd0;
    end
    if (rf_load_r && src_lu_r) begin
      clr_s[rf_dest_r] = 1'b1;
    end else begin
      clr_s = 32'd0;
    end
    pending_s = ((pending_r & ~clr_s) | set_s) & 32'hFFFF_FFFE;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= pending_s;
    end
  end

  // Starvation: count cycles a buffered result waits; request a bubble once the limit is reached
  always_comb begin
    starve_cnt_s   = starve_cnt_r;
    wb_stall_req_s = 1'b0;
    if (fifo_empty_s || pop_s) begin
      starve_cnt_s   = STV_ZERO;
      wb_stall_req_s = 1'b0;
    end else if (starve_cnt_r >= STV_LIMIT) begin
      starve_cnt_s   = STV_LIMIT;
      wb_stall_req_s = 1'b1;
    end else begin
      starve_cnt_s   = starve_cnt_r + STV_ONE;
      wb_stall_req_s = 1'b0;
    end
  end

  // Starvation counter and bubble request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r   <= STV_ZERO;
      wb_stall_req_r <= 1'b0;
    end else begin
      starve_cnt_r   <= starve_cnt_s;
      wb_stall_req_r <= wb_stall_req_s;
    end
  end

  assign hazard_stall = ((rs1 != 5'd0) && pending_r[rs1]) ||
                        ((rs2 != 5'd0) && pending_r[rs2]);

  assign lu_ready     = lu_ready_r;
  assign wb_stall_req = wb_stall_req_r;
  assign rf_load      = rf_load_r;
  assign rf_dest      = rf_dest_r;
  assign rf_in        = rf_in_r;
  assign pending      = pending_r;

endmodule
